pm1_arith_core: RTL and testbench

- Arithmetic support core for the Pollard p-1 factoring datapath.
- Contains three independent engines sharing one clock and one reset:
  - e-finder: smoothness exponent e = lcm(1..B).
  - log engine: floor(log_base(N)).
  - GCD engine: final gcd(N, x) step that yields a prime factor.
- The top-level sequencer starts each engine and waits on its done/ready flag.

---
 rtl/pm1_arith_core.sv | 209 ++++++++++++++++++++
 tb/tb_pm1_arith_core.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/pm1_arith_core.sv
// Arithmetic support core for the Pollard p-1 datapath: lcm(1..B) finder,
// integer log engine and binary GCD engine, all independent on one clock.
module pm1_arith_core #(
    parameter int W  = 64,
    parameter int RW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [W-1:0]  e_boundary,
    output logic [W-1:0]  e_value,
    output logic          e_done,
    input  logic          log_enable,
    input  logic [W-1:0]  log_boundary,
    input  logic [8:0]    log_base,
    output logic [7:0]    log_exponent,
    output logic          log_ready,
    input  logic          gcd_start,
    input  logic [W-1:0]  gcd_a,
    input  logic [W-1:0]  gcd_b,
    output logic [RW-1:0] gcd_result,
    output logic          gcd_done
);

    typedef enum logic [2:0] {E_CAPTURE, E_CHECK, E_TRIAL, E_REM, E_POW, E_DONE} eState_t;
    typedef enum logic [1:0] {L_IDLE, L_RUN, L_READY} lState_t;
    typedef enum logic       {G_IDLE, G_RUN} gState_t;

    eState_t        eState;
    logic [W-1:0]   eBound, eAcc, ePow;
    logic [W:0]     eCand, eDiv, eRem;
    logic [2*W+1:0] eDivSq;
    logic [2*W:0]   ePowNext;

    lState_t        lState;
    logic [W-1:0]   logN, logPow;
    logic [8:0]     logBase;
    logic [7:0]     logK;
    logic [W+8:0]   logNext;

    gState_t        gState;
    logic [W-1:0]   gA, gB, gDiff;
    logic [6:0]     gShift;

    // NOTE: every always_comb output is assigned on every path, so no latch is inferred.
    always_comb begin
        eDivSq   = (2*W+2)'(eDiv) * (2*W+2)'(eDiv);
        ePowNext = (2*W+1)'(ePow) * (2*W+1)'(eCand);
        logNext  = (W+9)'(logPow) * (W+9)'(logBase);
        gDiff    = (gA >= gB) ? gA - gB : gB - gA;
    end

    // e-finder: walk candidates 2..B, trial-divide by repeated subtraction,
    // and fold the largest prime power <= B into the accumulator.
    // NOTE: sequential state uses non-blocking assignments so every register
    // sees the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (reset) begin
            eState  <= E_CAPTURE;
            eBound  <= '0;
            eAcc    <= '0;
            ePow    <= '0;
            eCand   <= '0;
            eDiv    <= '0;
            eRem    <= '0;
            e_value <= '0;
            e_done  <= 1'b0;
        end else begin
            case (eState)
                E_CAPTURE: begin
                    eBound <= e_boundary;
                    eAcc   <= W'(1);
                    eCand  <= (W+1)'(2);
                    eState <= E_CHECK;
                end
                E_CHECK: begin
                    if (eCand > {1'b0, eBound}) begin
                        e_value <= eAcc;
                        e_done  <= 1'b1;
                        eState  <= E_DONE;
                    end else begin
                        eDiv   <= (W+1)'(2);
                        eState <= E_TRIAL;
                    end
                end
                E_TRIAL: begin
                    if (eDivSq > (2*W+2)'(eCand)) begin
                        ePow   <= eCand[W-1:0];
                        eState <= E_POW;
                    end else begin
                        eRem   <= eCand;
                        eState <= E_REM;
                    end
                end
                E_REM: begin
                    if (eRem >= eDiv) begin
                        eRem <= eRem - eDiv;
                    end else if (eRem == '0) begin
                        eCand  <= eCand + (W+1)'(1);
                        eState <= E_CHECK;
                    end else begin
                        eDiv   <= eDiv + (W+1)'(1);
                        eState <= E_TRIAL;
                    end
                end
                E_POW: begin
                    if (ePowNext <= (2*W+1)'(eBound)) begin
                        ePow <= ePowNext[W-1:0];
                    end else begin
                        eAcc   <= eAcc * ePow;
                        eCand  <= eCand + (W+1)'(1);
                        eState <= E_CHECK;
                    end
                end
                E_DONE:  eState <= E_DONE;
                default: eState <= E_DONE;
            endcase
        end
    end

    // Log engine: multiply up from 1 until the next power would exceed N.
    always_ff @(posedge clk) begin
        if (reset) begin
            lState       <= L_IDLE;
            logN         <= '0;
            logPow       <= '0;
            logBase      <= '0;
            logK         <= '0;
            log_exponent <= '0;
            log_ready    <= 1'b0;
        end else begin
            case (lState)
                L_IDLE: begin
                    if (log_enable) begin
                        logN    <= log_boundary;
                        logBase <= log_base;
                        logK    <= '0;
                        logPow  <= W'(1);
                        lState  <= L_RUN;
                    end
                end
                L_RUN: begin
                    if (logBase < 9'd2 || logK == 8'hFF || logNext > (W+9)'(logN)) begin
                        log_exponent <= logK;
                        log_ready    <= 1'b1;
                        lState       <= L_READY;
                    end else begin
                        logPow <= logNext[W-1:0];
                        logK   <= logK + 8'd1;
                    end
                end
                L_READY: begin
                    if (!log_enable) begin
                        log_ready <= 1'b0;
                        lState    <= L_IDLE;
                    end
                end
                default: lState <= L_IDLE;
            endcase
        end
    end

    // Binary GCD: strip common factors of two into gShift, then subtract odd
    // operands; when one side reaches zero the other, shifted back, is the gcd.
    always_ff @(posedge clk) begin
        if (reset) begin
            gState     <= G_IDLE;
            gA         <= '0;
            gB         <= '0;
            gShift     <= '0;
            gcd_result <= '0;
            gcd_done   <= 1'b0;
        end else begin
            case (gState)
                G_IDLE: begin
                    if (gcd_start) begin
                        gA       <= gcd_a;
                        gB       <= gcd_b;
                        gShift   <= '0;
                        gcd_done <= 1'b0;
                        gState   <= G_RUN;
                    end
                end
                G_RUN: begin
                    if (gA == '0 || gB == '0) begin
                        gcd_result <= RW'((gA | gB) << gShift);
                        gcd_done   <= 1'b1;
                        gState     <= G_IDLE;
                    end else begin
                        case ({gA[0], gB[0]})
                            2'b00: begin
                                gA     <= gA >> 1;
                                gB     <= gB >> 1;
                                gShift <= gShift + 7'd1;
                            end
                            2'b01: gA <= gA >> 1;
                            2'b10: gB <= gB >> 1;
                            default: begin
                                if (gA >= gB) gA <= gDiff >> 1;
                                else          gB <= gDiff >> 1;
                            end
                        endcase
                    end
                end
                default: gState <= G_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pm1_arith_core.sv
// Directed bench for pm1_arith_core: expected results are queued at stimulus
// time and popped when the matching engine raises its done/ready flag.
module tb_pm1_arith_core;
    localparam int W  = 64;
    localparam int RW = 32;
    localparam logic [W-1:0] E40 = 64'd5342931457063200;

    logic          clk = 1'b0;
    logic          reset;
    logic [W-1:0]  e_boundary;
    logic [W-1:0]  e_value;
    logic          e_done;
    logic          log_enable;
    logic [W-1:0]  log_boundary;
    logic [8:0]    log_base;
    logic [7:0]    log_exponent;
    logic          log_ready;
    logic          gcd_start;
    logic [W-1:0]  gcd_a;
    logic [W-1:0]  gcd_b;
    logic [RW-1:0] gcd_result;
    logic          gcd_done;

    pm1_arith_core #(.W(W), .RW(RW)) dut (
        .clk(clk), .reset(reset),
        .e_boundary(e_boundary), .e_value(e_value), .e_done(e_done),
        .log_enable(log_enable), .log_boundary(log_boundary), .log_base(log_base),
        .log_exponent(log_exponent), .log_ready(log_ready),
        .gcd_start(gcd_start), .gcd_a(gcd_a), .gcd_b(gcd_b),
        .gcd_result(gcd_result), .gcd_done(gcd_done)
    );

    always #5 clk = ~clk;

    int checkCount = 0;
    int passCount  = 0;

    logic [W-1:0]  eQ[$];
    logic [7:0]    logQ[$];
    logic [RW-1:0] gcdQ[$];

    logic          holdOk;
    logic          eSeen, lSeen, gSeen;
    int            cycles;

    task automatic check(input string tag, input logic [W-1:0] observed, input logic [W-1:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    endtask

    task automatic runLog(input string tag, input logic [W-1:0] n, input logic [8:0] b, input logic [7:0] expK);
        int lat;
        logic [7:0] exp;
        lat = 0;
        @(negedge clk);
        log_boundary = n;
        log_base     = b;
        log_enable   = 1'b1;
        logQ.push_back(expK);
        do begin
            @(negedge clk);
            lat++;
        end while (!log_ready && lat < 400);
        exp = logQ.pop_front();
        check({tag, " ready"}, W'(log_ready), 1);
        check({tag, " exponent"}, W'(log_exponent), W'(exp));
        check({tag, " latency"}, W'(lat), W'(int'(exp) + 2));
        @(negedge clk);
        check({tag, " ready held"}, W'(log_ready), 1);
        log_enable = 1'b0;
        @(negedge clk);
        check({tag, " ready drop"}, W'(log_ready), 0);
        check({tag, " exponent kept"}, W'(log_exponent), W'(exp));
    endtask

    task automatic runGcd(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input logic [RW-1:0] expG);
        int lat;
        @(negedge clk);
        gcd_a     = a;
        gcd_b     = b;
        gcd_start = 1'b1;
        gcdQ.push_back(expG);
        @(negedge clk);
        gcd_start = 1'b0;
        lat = 0;
        while (!gcd_done && lat < 500) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " done"}, W'(gcd_done), 1);
        check({tag, " result"}, W'(gcd_result), W'(gcdQ.pop_front()));
    endtask

    initial begin
        reset        = 1'b1;
        e_boundary   = 64'd40;
        log_enable   = 1'b0;
        log_boundary = '0;
        log_base     = '0;
        gcd_start    = 1'b0;
        gcd_a        = '0;
        gcd_b        = '0;
        repeat (3) @(negedge clk);

        check("reset e_value", e_value, 0);
        check("reset e_done", W'(e_done), 0);
        check("reset log_exponent", W'(log_exponent), 0);
        check("reset log_ready", W'(log_ready), 0);
        check("reset gcd_result", W'(gcd_result), 0);
        check("reset gcd_done", W'(gcd_done), 0);

        // e-finder with B=40, then confirm it holds and ignores a new bound.
        eQ.push_back(E40);
        reset = 1'b0;
        cycles = 0;
        while (!e_done && cycles < 20000) begin
            @(negedge clk);
            cycles++;
        end
        check("e done", W'(e_done), 1);
        check("e value", e_value, eQ.pop_front());
        e_boundary = 64'd7;
        holdOk = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (e_done !== 1'b1 || e_value !== E40) holdOk = 1'b0;
        end
        check("e hold 100", W'(holdOk), 1);
        e_boundary = 64'd40;

        runLog("log 1000 b2", 64'd1000, 9'd2, 8'd9);
        runLog("log 1024 b2", 64'd1024, 9'd2, 8'd10);
        runLog("log 80 b3", 64'd80, 9'd3, 8'd3);
        runLog("log N0", 64'd0, 9'd2, 8'd0);
        runLog("log base1", 64'd500, 9'd1, 8'd0);
        runLog("log max b2", {W{1'b1}}, 9'd2, 8'd63);

        runGcd("gcd 8051,194", 64'd8051, 64'd194, 32'd97);
        runGcd("gcd 0,12", 64'd0, 64'd12, 32'd12);
        runGcd("gcd 12,0", 64'd12, 64'd0, 32'd12);
        runGcd("gcd 17,17", 64'd17, 64'd17, 32'd17);
        runGcd("gcd 2^40,3*2^36", 64'd1 << 40, 64'd3 << 36, 32'd0);

        // Second start pulse while busy must be ignored.
        @(negedge clk);
        gcd_a = 64'd8051;
        gcd_b = 64'd194;
        gcd_start = 1'b1;
        gcdQ.push_back(32'd97);
        @(negedge clk);
        gcd_start = 1'b0;
        @(negedge clk);
        gcd_b = 64'd83;
        gcd_start = 1'b1;
        @(negedge clk);
        gcd_start = 1'b0;
        cycles = 0;
        while (!gcd_done && cycles < 500) begin
            @(negedge clk);
            cycles++;
        end
        check("gcd busy done", W'(gcd_done), 1);
        check("gcd busy result", W'(gcd_result), W'(gcdQ.pop_front()));

        // Reset mid-run clears the held result and nothing resumes.
        @(negedge clk);
        gcd_b = 64'd194;
        gcd_start = 1'b1;
        @(negedge clk);
        gcd_start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("mid reset gcd_done", W'(gcd_done), 0);
        check("mid reset gcd_result", W'(gcd_result), 0);
        check("mid reset e_done", W'(e_done), 0);
        check("mid reset e_value", e_value, 0);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        check("no resume gcd_done", W'(gcd_done), 0);

        // All three engines started in the same cycle.
        reset = 1'b1;
        gcd_start = 1'b1;
        @(negedge clk);
        check("start under reset", W'(gcd_done), 0);
        reset        = 1'b0;
        log_boundary = 64'd1000;
        log_base     = 9'd2;
        log_enable   = 1'b1;
        gcd_a        = 64'd8051;
        gcd_b        = 64'd194;
        eQ.push_back(E40);
        logQ.push_back(8'd9);
        gcdQ.push_back(32'd97);
        @(negedge clk);
        gcd_start = 1'b0;
        eSeen = 1'b0;
        lSeen = 1'b0;
        gSeen = 1'b0;
        cycles = 0;
        while (!(eSeen && lSeen && gSeen) && cycles < 20000) begin
            if (e_done && !eSeen) begin
                eSeen = 1'b1;
                check("par e value", e_value, eQ.pop_front());
            end
            if (log_ready && !lSeen) begin
                lSeen = 1'b1;
                check("par log exponent", W'(log_exponent), W'(logQ.pop_front()));
            end
            if (gcd_done && !gSeen) begin
                gSeen = 1'b1;
                check("par gcd result", W'(gcd_result), W'(gcdQ.pop_front()));
            end
            @(negedge clk);
            cycles++;
        end
        check("par all finished", W'({eSeen, lSeen, gSeen}), 3'b111);
        log_enable = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
